// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Consumer side of the PLL interface. Synchronizes the PLL lock flag into the
// PLL output clock domain, filters it, holds the downstream core reset for a
// fixed number of cycles and then releases it together with a ready flag.
// Any loss of lock while running re-asserts the core reset and sets a sticky
// lock_lost flag.
//
// Optional feature macro: PLL_LOCK_LOSS_CNT_EN
//   defined   : lost_count counts RUN -> WAIT_LOCK transitions, saturating.
//   undefined : lost_count is tied to zero and no counter flops exist.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_LOCK | core held in reset, waiting for synchronized lock
// FILTER    | lock seen, must stay high LOCK_FILTER consecutive cycles
// HOLD      | lock filtered, core reset held for RST_CYCLES cycles
// RUN       | core reset released, ready asserted

module pll_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RST_CYCLES  = 64,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked,
  output logic                  core_reset,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] lost_count
);

  // One counter serves both the filter and the hold phase, so it is sized for
  // the longer of the two.
  localparam int CNT_MAX = (LOCK_FILTER > RST_CYCLES) ? LOCK_FILTER : RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t                 state_q;
  state_t                 state_n;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_n;
  logic                   core_reset_q;
  logic                   ready_q;
  logic                   lock_lost_q;
  logic                   lock_lost_n;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock flag synchronizer chain; cleared by reset so the full latency
  // applies again after any reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  // Next-state logic; the counter is cleared whenever a state is entered.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    lock_lost_n = lock_lost_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (locked_s) begin
          state_n = FILTER;
        end
      end
      FILTER: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n     = WAIT_LOCK;
          lock_lost_n = 1'b1;
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered outputs all move on the same edge, so
  // ready is always the complement of core_reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      core_reset_q <= (state_n != RUN);
      ready_q      <= (state_n == RUN);
      lock_lost_q  <= lock_lost_n;
    end
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic                  loss_evt;
  logic [LOSS_CNT_W-1:0] lost_cnt_q;

  assign loss_evt = (state_q == RUN) && !locked_s;

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clock) begin
    if (reset) begin
      lost_cnt_q <= '0;
    end else if (loss_evt && (lost_cnt_q != {LOSS_CNT_W{1'b1}})) begin
      lost_cnt_q <= lost_cnt_q + 1'b1;
    end
  end

  assign lost_count = lost_cnt_q;
`else
  assign lost_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer. The reference model tracks how many
// consecutive synchronized lock samples have been high; the core is ready once
// that run reaches LOCK_FILTER + RST_CYCLES + 1.
module tb_pll_reset_sequencer;

  localparam int S   = 2;
  localparam int F   = 16;
  localparam int R   = 64;
  localparam int W   = 2;
  localparam int LAT = S + 1 + F + R;
  localparam int RUN_STREAK = F + R + 1;
  localparam int LC_MAX = (1 << W) - 1;

  logic         clock;
  logic         reset;
  logic         locked;
  logic         core_reset;
  logic         ready;
  logic         lock_lost;
  logic [W-1:0] lost_count;

  int pass_cnt;
  int total_cnt;

  // reference model state
  bit m_pipe[$];
  int m_streak;
  bit m_ready;
  bit m_lost;
  int m_lc;

  pll_reset_sequencer #(
    .SYNC_STAGES(S),
    .LOCK_FILTER(F),
    .RST_CYCLES (R),
    .LOSS_CNT_W (W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .locked    (locked),
    .core_reset(core_reset),
    .ready     (ready),
    .lock_lost (lock_lost),
    .lost_count(lost_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance one edge and update the model.
  task automatic tick(input bit l, input bit r);
    bit ls;
    locked = l;
    reset  = r;
    @(posedge clock);
    if (r) begin
      m_pipe = {};
      repeat (S) m_pipe.push_back(1'b0);
      m_streak = 0;
      m_ready  = 1'b0;
      m_lost   = 1'b0;
      m_lc     = 0;
    end else begin
      ls = m_pipe.pop_front();
      m_pipe.push_back(l);
      if (ls) begin
        if (m_streak < 100000) m_streak++;
        m_ready = (m_streak >= RUN_STREAK);
      end else begin
        if (m_ready) begin
          m_lost = 1'b1;
`ifdef PLL_LOCK_LOSS_CNT_EN
          if (m_lc < LC_MAX) m_lc++;
`endif
        end
        m_streak = 0;
        m_ready  = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3 + 200; k++) begin
      tick(1'b0, k < 3);
      total_cnt++;
      if (core_reset !== 1'b1) $display("FAIL reset_core_reset cyc=%0d got=%b exp=1", k, core_reset);
      else pass_cnt++;
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL reset_ready cyc=%0d got=%b exp=0", k, ready);
      else pass_cnt++;
      total_cnt++;
      if (lock_lost !== 1'b0) $display("FAIL reset_lock_lost cyc=%0d got=%b exp=0", k, lock_lost);
      else pass_cnt++;
      total_cnt++;
      if (lost_count !== '0) $display("FAIL reset_lost_count cyc=%0d got=%0d exp=0", k, lost_count);
      else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    for (int k = 1; k <= LAT + 5; k++) begin
      tick(1'b1, 1'b0);
      if (k == LAT - 1) begin
        total_cnt++;
        if (ready !== 1'b0 || core_reset !== 1'b1)
          $display("FAIL latency_early edge=%0d got ready=%b core_reset=%b exp 0/1", k, ready, core_reset);
        else pass_cnt++;
      end
      if (k == LAT) begin
        total_cnt++;
        if (ready !== 1'b1 || core_reset !== 1'b0)
          $display("FAIL latency_exact edge=%0d got ready=%b core_reset=%b exp 1/0", k, ready, core_reset);
        else pass_cnt++;
      end
      total_cnt++;
      if (ready !== m_ready) $display("FAIL latency_model edge=%0d got=%b exp=%b", k, ready, m_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_glitch();
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 130; k++) begin
      tick(k != 40, 1'b0);
      if (k == LAT || k == 41 + LAT - 2) begin
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL glitch_not_ready edge=%0d got=%b exp=0", k, ready);
        else pass_cnt++;
      end
      if (k == 41 + LAT - 1) begin
        total_cnt++;
        if (ready !== 1'b1) $display("FAIL glitch_ready edge=%0d got=%b exp=1", k, ready);
        else pass_cnt++;
      end
      total_cnt++;
      if (ready !== m_ready) $display("FAIL glitch_model edge=%0d got=%b exp=%b", k, ready, m_ready);
      else pass_cnt++;
    end
    total_cnt++;
    if (lock_lost !== 1'b0) $display("FAIL glitch_lock_lost got=%b exp=0", lock_lost);
    else pass_cnt++;
  endtask

  task automatic test_run_drop();
    for (int k = 1; k <= 90; k++) begin
      tick(k != 1, 1'b0);
      if (k == S + 1) begin
        total_cnt++;
        if (core_reset !== 1'b1 || ready !== 1'b0)
          $display("FAIL drop_core_reset edge=%0d got core_reset=%b ready=%b exp 1/0", k, core_reset, ready);
        else pass_cnt++;
      end
      if (k >= S + 1) begin
        total_cnt++;
        if (lock_lost !== 1'b1) $display("FAIL drop_lock_lost edge=%0d got=%b exp=1", k, lock_lost);
        else pass_cnt++;
      end
      if (k == LAT) begin
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL drop_not_ready edge=%0d got=%b exp=0", k, ready);
        else pass_cnt++;
      end
      if (k == LAT + 1) begin
        total_cnt++;
        if (ready !== 1'b1) $display("FAIL drop_ready edge=%0d got=%b exp=1", k, ready);
        else pass_cnt++;
      end
      total_cnt++;
      if (ready !== m_ready || core_reset !== !m_ready)
        $display("FAIL drop_model edge=%0d got ready=%b core_reset=%b exp ready=%b", k, ready, core_reset, m_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_with_drop();
    tick(1'b0, 1'b1);
    total_cnt++;
    if (core_reset !== 1'b1 || ready !== 1'b0 || lock_lost !== 1'b0 || lost_count !== '0)
      $display("FAIL reset_drop got core_reset=%b ready=%b lock_lost=%b lost_count=%0d exp 1/0/0/0",
               core_reset, ready, lock_lost, lost_count);
    else pass_cnt++;
  endtask

  task automatic test_loss_count();
    int exp_tab[5];
`ifdef PLL_LOCK_LOSS_CNT_EN
    exp_tab = '{1, 2, 3, 3, 3};
`else
    exp_tab = '{0, 0, 0, 0, 0};
`endif
    tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      repeat (LAT + 2) tick(1'b1, 1'b0);
      total_cnt++;
      if (ready !== 1'b1) $display("FAIL loss_run iter=%0d got ready=%b exp=1", i, ready);
      else pass_cnt++;
      tick(1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b0);
      total_cnt++;
      if (lost_count !== W'(exp_tab[i]))
        $display("FAIL loss_count iter=%0d got=%0d exp=%0d", i, lost_count, exp_tab[i]);
      else pass_cnt++;
      total_cnt++;
      if (lost_count !== W'(m_lc)) $display("FAIL loss_model iter=%0d got=%0d exp=%0d", i, lost_count, m_lc);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int hi_len;
    int lo_len;
    bit r;
    for (int seg = 0; seg < 25; seg++) begin
      hi_len = $urandom_range(120, 1);
      lo_len = $urandom_range(4, 1);
      for (int k = 0; k < hi_len + lo_len; k++) begin
        r = ($urandom_range(199, 0) == 0);
        tick(k < hi_len, r);
        total_cnt++;
        if (ready !== m_ready) $display("FAIL rand_ready seg=%0d k=%0d got=%b exp=%b", seg, k, ready, m_ready);
        else pass_cnt++;
        total_cnt++;
        if (core_reset !== !ready) $display("FAIL rand_invariant seg=%0d k=%0d ready=%b core_reset=%b", seg, k, ready, core_reset);
        else pass_cnt++;
        total_cnt++;
        if (lock_lost !== m_lost) $display("FAIL rand_lock_lost seg=%0d k=%0d got=%b exp=%b", seg, k, lock_lost, m_lost);
        else pass_cnt++;
        total_cnt++;
        if (lost_count !== W'(m_lc)) $display("FAIL rand_lost_count seg=%0d k=%0d got=%0d exp=%0d", seg, k, lost_count, m_lc);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    locked    = 1'b0;
    reset     = 1'b1;
    m_pipe    = {};
    repeat (S) m_pipe.push_back(1'b0);
    m_streak  = 0;
    m_ready   = 1'b0;
    m_lost    = 1'b0;
    m_lc      = 0;

    test_reset();
    test_latency();
    test_hold_glitch();
    test_run_drop();
    test_reset_with_drop();
    test_loss_count();
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
